// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two circular buffer, flush and reset clear it synchronously.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Flush outranks both push and pop so the queue is empty the following cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request at a time, results queued for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_result,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  logic         enable_nxt;
  logic [31:0]  addr_nxt;
  logic         push, flush, full, empty;
  fetch_entry_t head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= align_pc(RESET_PC);
      mem_enable <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      mem_enable <= enable_nxt;
      mem_addr   <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    enable_nxt   = mem_enable;
    addr_nxt     = mem_addr;
    push         = 1'b0;
    flush        = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = align_pc(redirect_pc);
        end else if (!full) begin
          state_nxt  = WAIT;
          enable_nxt = 1'b1;
          addr_nxt   = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = align_pc(redirect_pc);
          if (mem_valid) begin
            enable_nxt = 1'b0;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = DROP;
          end
        end else if (mem_valid) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + INSTR_BYTES;
          enable_nxt   = 1'b0;
          state_nxt    = IDLE;
        end
      end
      DROP: begin
        // Stale response still in flight: swallow it without advancing fetch_pc.
        if (redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = align_pc(redirect_pc);
        end
        if (mem_valid) begin
          enable_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  fetch_fifo #(.DEPTH(QDEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_valid & out_ready),
    .flush (flush),
    .wdata ({fetch_pc, mem_result}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: dut runs with QDEPTH=2/RESET_PC=0, dut_b with QDEPTH=4/RESET_PC=0x38.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, mem_enable, mem_valid, redirect, out_valid, out_ready;
  logic [31:0] mem_addr, mem_result, redirect_pc, out_instr, out_pc;

  logic        rst_b, mem_enable_b, mem_valid_b, redirect_b, out_valid_b, out_ready_b;
  logic [31:0] mem_addr_b, mem_result_b, redirect_pc_b, out_instr_b, out_pc_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .mem_enable(mem_enable), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_result(mem_result), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.RESET_PC(32'h38), .QDEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .mem_enable(mem_enable_b), .mem_addr(mem_addr_b),
    .mem_valid(mem_valid_b), .mem_result(mem_result_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_instr(out_instr_b), .out_pc(out_pc_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_result = '0; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;
    rst_b = 1'b1; mem_valid_b = 1'b0; mem_result_b = '0; redirect_b = 1'b0;
    redirect_pc_b = '0; out_ready_b = 1'b0;
    tick(); tick();
    check("rst_en", mem_enable, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_oval", out_valid, 0);

    // Sequential fetch, 1-cycle latency, decode always ready
    rst = 1'b0;
    tick();
    check("seq0_en", mem_enable, 1);
    check("seq0_addr", mem_addr, 32'h0);
    mem_valid = 1'b1; mem_result = 32'hA000_0001;
    tick();
    mem_valid = 1'b0;
    check("seq0_en_off", mem_enable, 0);
    check("seq0_oval", out_valid, 1);
    check("seq0_pc", out_pc, 32'h0);
    check("seq0_instr", out_instr, 32'hA000_0001);
    tick();
    check("seq1_en", mem_enable, 1);
    check("seq1_addr", mem_addr, 32'h4);
    check("seq1_popped", out_valid, 0);
    mem_valid = 1'b1; mem_result = 32'hA000_0002;
    tick();
    mem_valid = 1'b0;
    check("seq1_pc", out_pc, 32'h4);
    check("seq1_instr", out_instr, 32'hA000_0002);
    tick();
    check("seq2_addr", mem_addr, 32'h8);
    mem_valid = 1'b1; mem_result = 32'hA000_0003;
    tick();
    mem_valid = 1'b0;
    check("seq2_pc", out_pc, 32'h8);
    check("seq2_instr", out_instr, 32'hA000_0003);

    // Reset mid-request, then a late response must be ignored
    out_ready = 1'b0;
    tick();
    check("pre_rst_addr", mem_addr, 32'hC);
    rst = 1'b1;
    tick();
    check("midrst_en", mem_enable, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_oval", out_valid, 0);
    rst = 1'b0; mem_valid = 1'b1; mem_result = 32'hDEAD_BEEF;
    tick();
    mem_valid = 1'b0;
    check("late_no_push", out_valid, 0);
    check("late_en", mem_enable, 1);
    check("late_addr", mem_addr, 32'h0);

    // Backpressure: two entries fill the queue, issue stalls until a pop
    mem_valid = 1'b1; mem_result = 32'hB000_0000;
    tick();
    mem_valid = 1'b0;
    tick();
    check("bp1_addr", mem_addr, 32'h4);
    mem_valid = 1'b1; mem_result = 32'hB000_0004;
    tick();
    mem_valid = 1'b0;
    tick();
    check("bp_full_en", mem_enable, 0);
    tick();
    check("bp_full_en2", mem_enable, 0);
    check("bp_full_oval", out_valid, 1);
    check("bp_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_pop_pc", out_pc, 32'h4);
    check("bp_pop_en", mem_enable, 0);
    tick();
    check("bp_reissue_en", mem_enable, 1);
    check("bp_reissue_addr", mem_addr, 32'h8);
    mem_valid = 1'b1; mem_result = 32'hB000_0008;
    tick();
    mem_valid = 1'b0;
    tick();
    check("bp_full_again", mem_enable, 0);

    // Redirect in IDLE, then redirect in WAIT discards the outstanding response
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    check("rd_idle_flush", out_valid, 0);
    check("rd_idle_en", mem_enable, 0);
    tick();
    check("rd20_addr", mem_addr, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    check("drop_en_hold", mem_enable, 1);
    check("drop_addr_hold", mem_addr, 32'h20);
    mem_valid = 1'b1; mem_result = 32'hCCCC_0020;
    tick();
    mem_valid = 1'b0;
    check("drop_no_push", out_valid, 0);
    check("drop_en_off", mem_enable, 0);
    tick();
    check("rd100_addr", mem_addr, 32'h100);
    check("rd100_oval", out_valid, 0);

    // Address wrap at the top of the address space
    out_ready = 1'b1;
    mem_valid = 1'b1; mem_result = 32'hD000_0100;
    tick();
    mem_valid = 1'b0;
    check("pc100_pc", out_pc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("wrap_flush", out_valid, 0);
    tick();
    check("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
    mem_valid = 1'b1; mem_result = 32'hE000_FFFC;
    tick();
    mem_valid = 1'b0;
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_instr", out_instr, 32'hE000_FFFC);
    tick();
    check("wrap_next_en", mem_enable, 1);
    check("wrap_next_addr", mem_addr, 32'h0);

    // dut_b: redirect coincident with the response while two entries are queued
    rst_b = 1'b0;
    tick();
    check("b_first_addr", mem_addr_b, 32'h38);
    mem_valid_b = 1'b1; mem_result_b = 32'hF000_0038;
    tick();
    mem_valid_b = 1'b0;
    tick();
    check("b_second_addr", mem_addr_b, 32'h3C);
    mem_valid_b = 1'b1; mem_result_b = 32'hF000_003C;
    tick();
    mem_valid_b = 1'b0;
    tick();
    check("b_third_en", mem_enable_b, 1);
    check("b_third_addr", mem_addr_b, 32'h40);
    check("b_head_pc", out_pc_b, 32'h38);
    redirect_b = 1'b1; redirect_pc_b = 32'h200;
    mem_valid_b = 1'b1; mem_result_b = 32'hF000_0040;
    out_ready_b = 1'b1;
    tick();
    redirect_b = 1'b0; mem_valid_b = 1'b0; out_ready_b = 1'b0;
    check("b_flush_oval", out_valid_b, 0);
    check("b_flush_en", mem_enable_b, 0);
    tick();
    check("b_new_en", mem_enable_b, 1);
    check("b_new_addr", mem_addr_b, 32'h200);
    check("b_new_oval", out_valid_b, 0);
    mem_valid_b = 1'b1; mem_result_b = 32'hF000_0200;
    tick();
    mem_valid_b = 1'b0;
    check("b_head_after_pc", out_pc_b, 32'h200);
    check("b_head_after_instr", out_instr_b, 32'hF000_0200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
